// File: rtl/score_text_ctrl.sv
// Score-to-text updater: converts two saturated 0..99 scores to ASCII digits and
// writes them to the text buffer during vertical blanking. Optional macro: SCORE_TEXT_BLANK_EN.
module score_text_ctrl #(
   parameter int unsigned TEXT_ROW = 0,
   parameter int unsigned COL_L    = 2,
   parameter int unsigned COL_R    = 10
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic       vblnk_in,
   input  logic       upd_req,
   input  logic [6:0] score_l,
   input  logic [6:0] score_r,
   output logic       upd_ack,
   output logic       busy,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [6:0] wr_data
);

   localparam logic [3:0] ROW4  = 4'(TEXT_ROW);
   localparam logic [3:0] COLL4 = 4'(COL_L);
   localparam logic [3:0] COLR4 = 4'(COL_R);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV,
      S_WAIT_VB,
      S_WRITE,
      S_DONE
   } state_t;

   state_t     r_state;
   logic [6:0] r_val_l;
   logic [6:0] r_val_r;
   logic [3:0] r_tens_l;
   logic [3:0] r_tens_r;
   logic [1:0] r_idx;

   logic [6:0] w_sat_l;
   logic [6:0] w_sat_r;
   logic [3:0] w_digit;
   logic [3:0] w_col;
   logic [6:0] w_char;

   assign w_sat_l = (score_l > 7'd99) ? 7'd99 : score_l;
   assign w_sat_r = (score_r > 7'd99) ? 7'd99 : score_r;

   // Write order: L tens, L units, R tens, R units; after CONV the latched values hold the units.
   always_comb begin
      w_digit = '0;
      case (r_idx)
         2'd0: w_digit = r_tens_l;
         2'd1: w_digit = r_val_l[3:0];
         2'd2: w_digit = r_tens_r;
         2'd3: w_digit = r_val_r[3:0];
         default: w_digit = '0;
      endcase
   end

   // 4-bit add: column wraps 15 -> 0 inside the same row.
   assign w_col = (r_idx[1] ? COLR4 : COLL4) + {3'b000, r_idx[0]};

   always_comb begin
      w_char = 7'h30 + {3'b000, w_digit};
`ifdef SCORE_TEXT_BLANK_EN
      if (!r_idx[0] && (w_digit == 4'd0)) begin
         w_char = 7'h20;
      end
`else
      w_char = 7'h30 + {3'b000, w_digit};
`endif
   end

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_val_l  <= '0;
         r_val_r  <= '0;
         r_tens_l <= '0;
         r_tens_r <= '0;
         r_idx    <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         upd_ack  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         wr_en   <= 1'b0;
         upd_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (upd_req) begin
                  r_val_l  <= w_sat_l;
                  r_val_r  <= w_sat_r;
                  r_tens_l <= '0;
                  r_tens_r <= '0;
                  r_idx    <= '0;
                  r_state  <= S_CONV;
                  busy     <= 1'b1;
               end
            end
            S_CONV: begin
               if ((r_val_l < 7'd10) && (r_val_r < 7'd10)) begin
                  r_state <= S_WAIT_VB;
               end else begin
                  if (r_val_l >= 7'd10) begin
                     r_val_l  <= r_val_l - 7'd10;
                     r_tens_l <= r_tens_l + 4'd1;
                  end
                  if (r_val_r >= 7'd10) begin
                     r_val_r  <= r_val_r - 7'd10;
                     r_tens_r <= r_tens_r + 4'd1;
                  end
               end
            end
            S_WAIT_VB: begin
               if (vblnk_in) begin
                  r_state <= S_WRITE;
               end
            end
            S_WRITE: begin
               // Outside blanking the index is frozen and the write resumes where it stopped.
               if (vblnk_in) begin
                  wr_en   <= 1'b1;
                  wr_addr <= {ROW4, w_col};
                  wr_data <= w_char;
                  r_idx   <= r_idx + 2'd1;
                  if (r_idx == 2'd3) begin
                     r_state <= S_DONE;
                     upd_ack <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_score_text_ctrl.sv
// Scoreboard bench for score_text_ctrl: two instances (default and wrapped-column
// placement) share stimulus; expected writes come from decimal arithmetic on the scores.
module tb_score_text_ctrl;

   logic pclk = 1'b0;
   logic rst = 1'b0;
   logic vblnk_in = 1'b1;
   logic upd_req = 1'b0;
   logic [6:0] score_l = '0;
   logic [6:0] score_r = '0;

   logic [1:0]      ack;
   logic [1:0]      bsy;
   logic [1:0]      wen;
   logic [1:0][7:0] waddr;
   logic [1:0][6:0] wdata;

   typedef struct {
      bit         is_ack;
      logic [7:0] addr;
      logic [6:0] data;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_err = 0;
   int   n_chk = 0;
   int   wr_count[2] = '{0, 0};
   logic vb_at_edge = 1'b1;

   always #5 pclk = ~pclk;

   score_text_ctrl u_dut0 (
      .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in), .upd_req(upd_req),
      .score_l(score_l), .score_r(score_r),
      .upd_ack(ack[0]), .busy(bsy[0]), .wr_en(wen[0]),
      .wr_addr(waddr[0]), .wr_data(wdata[0])
   );

   score_text_ctrl #(.TEXT_ROW(5), .COL_L(7), .COL_R(15)) u_dut1 (
      .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in), .upd_req(upd_req),
      .score_l(score_l), .score_r(score_r),
      .upd_ack(ack[1]), .busy(bsy[1]), .wr_en(wen[1]),
      .wr_addr(waddr[1]), .wr_data(wdata[1])
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic int sat(input int s);
      return (s > 99) ? 99 : s;
   endfunction

   function automatic logic [6:0] tens_char(input int t);
`ifdef SCORE_TEXT_BLANK_EN
      if (t == 0) return 7'h20;
`endif
      return 7'(8'h30 + t);
   endfunction

   function automatic logic [7:0] addr_of(input int d, input int k);
      int base;
      base = (k < 2) ? ((d == 1) ? 7 : 2) : ((d == 1) ? 15 : 10);
      return {((d == 1) ? 4'd5 : 4'd0), 4'((base + (k % 2)) % 16)};
   endfunction

   function automatic void push_txn(input int l, input int r);
      int   dig[4];
      exp_t e;
      dig[0] = sat(l) / 10; dig[1] = sat(l) % 10;
      dig[2] = sat(r) / 10; dig[3] = sat(r) % 10;
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 4; k++) begin
            e.is_ack = 1'b0;
            e.addr   = addr_of(d, k);
            e.data   = (k % 2 == 0) ? tens_char(dig[k]) : 7'(8'h30 + dig[k]);
            if (d == 0) q0.push_back(e); else q1.push_back(e);
         end
         e.is_ack = 1'b1; e.addr = '0; e.data = '0;
         if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
   endfunction

   function automatic bit pop(input int d, output exp_t e);
      e = '{is_ack: 1'b0, addr: '0, data: '0};
      if (d == 0) begin
         if (q0.size() == 0) return 1'b0;
         e = q0.pop_front();
      end else begin
         if (q1.size() == 0) return 1'b0;
         e = q1.pop_front();
      end
      return 1'b1;
   endfunction

   always @(posedge pclk) vb_at_edge <= vblnk_in;

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge pclk);
         for (int d = 0; d < 2; d++) begin
            if (wen[d]) begin
               chk($sformatf("d%0d_wr_outside_vblank", d), {31'b0, ~vb_at_edge}, 0);
               if (!pop(d, e)) begin
                  n_chk++; n_err++;
                  $display("FAIL d%0d_unexpected_write: addr 0x%0h data 0x%0h, none expected", d, waddr[d], wdata[d]);
               end else if (e.is_ack) begin
                  n_chk++; n_err++;
                  $display("FAIL d%0d_write_order: write addr 0x%0h seen, upd_ack expected", d, waddr[d]);
               end else begin
                  chk($sformatf("d%0d_wr_addr", d), {24'b0, waddr[d]}, {24'b0, e.addr});
                  chk($sformatf("d%0d_wr_data", d), {25'b0, wdata[d]}, {25'b0, e.data});
               end
               wr_count[d]++;
            end
            if (ack[d]) begin
               n_chk++;
               if (!pop(d, e) || !e.is_ack) begin
                  n_err++;
                  $display("FAIL d%0d_upd_ack: got pulse=1 expected no pulse here", d);
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge pclk);
      #1;
   endtask

   task automatic run_txn(input int l, input int r, input bit chk_lat, input bit drop,
                          input bit rnd_vb, input bit repulse);
      int base, cnt, k, n_conv;
      base   = wr_count[0];
      n_conv = ((sat(l) / 10 > sat(r) / 10) ? sat(l) / 10 : sat(r) / 10) + 1;
      score_l = 7'(l);
      score_r = 7'(r);
      push_txn(l, r);
      upd_req = 1'b1;
      tick();
      upd_req = 1'b0;
      chk("busy_after_req", {31'b0, bsy[0]}, 1);
      cnt = 1;
      while (!wen[0] && cnt < 200) begin
         if (repulse) upd_req = (cnt >= 2 && cnt <= 4);
         if (rnd_vb) vblnk_in = ($urandom_range(0, 3) != 0);
         tick();
         cnt++;
      end
      upd_req = 1'b0;
      if (cnt >= 200) chk("first_write_timeout", {31'b0, wen[0]}, 1);
      else if (chk_lat) chk("first_write_latency", cnt, n_conv + 3);
      if (drop) begin
         k = 0;
         while (wr_count[0] - base < 2 && k < 50) begin tick(); k++; end
         vblnk_in = 1'b0;
         repeat (5) begin
            tick();
            chk("wr_en_low_in_gap", {31'b0, wen[0]}, 0);
         end
         vblnk_in = 1'b1;
      end
      k = 0;
      while (bsy != 2'b00 && k < 200) begin
         if (rnd_vb) vblnk_in = ($urandom_range(0, 3) != 0);
         tick();
         k++;
      end
      vblnk_in = 1'b1;
      if (k >= 200) chk("done_timeout", {31'b0, bsy[0]}, 0);
      repeat (3) tick();
      chk("idle_after_done", {30'b0, bsy}, 0);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("write_count", wr_count[0] - base, 4);
   endtask

   initial begin : stimulus
      int k;
      #1;
      chk("rst_busy", {31'b0, bsy[0]}, 0);
      chk("rst_wr_en", {31'b0, wen[0]}, 0);
      chk("rst_ack", {31'b0, ack[0]}, 0);
      chk("rst_wr_addr", {24'b0, waddr[0]}, 0);
      chk("rst_wr_data", {25'b0, wdata[0]}, 0);
      tick(); tick();
      rst = 1'b1;

      run_txn(42, 7, 1'b1, 1'b0, 1'b0, 1'b0);
      run_txn(120, 99, 1'b1, 1'b0, 1'b0, 1'b0);
      run_txn(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_txn(9, 10, 1'b1, 1'b0, 1'b0, 1'b0);
      run_txn(63, 88, 1'b1, 1'b1, 1'b0, 1'b0);
      run_txn(55, 31, 1'b1, 1'b0, 1'b0, 1'b1);

      // Reset asserted after the first write abandons the update.
      score_l = 7'd77; score_r = 7'd23;
      push_txn(77, 23);
      k = wr_count[0];
      upd_req = 1'b1; tick(); upd_req = 1'b0;
      while (wr_count[0] == k && k < 1000 && wr_count[0] - k < 1) begin
         tick();
         if ($time > 100000) break;
      end
      rst = 1'b0;
      #1;
      chk("async_rst_wr_en", {31'b0, wen[0]}, 0);
      chk("async_rst_busy", {30'b0, bsy}, 0);
      chk("async_rst_ack", {31'b0, ack[0]}, 0);
      chk("async_rst_wr_addr", {24'b0, waddr[0]}, 0);
      chk("async_rst_wr_data", {25'b0, wdata[0]}, 0);
      q0.delete();
      q1.delete();
      repeat (4) tick();
      rst = 1'b1;
      run_txn(5, 64, 1'b1, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 20; i++) begin
         run_txn($urandom_range(0, 127), $urandom_range(0, 127), (i % 2 == 0), 1'b0, (i % 2 == 1), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
